// File: rtl/four_bit_adder_pkg.sv
// ============================================================================
// Module      : four_bit_adder_pkg
// Description : Shared constants for the registered ripple-carry adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package four_bit_adder_pkg;

    localparam int ADDER_WIDTH = 4;

endpackage : four_bit_adder_pkg

`default_nettype wire

// File: rtl/four_bit_adder_full_adder.sv
// ============================================================================
// Module      : full_adder
// Description : One-bit combinational full-adder cell for the ripple chain.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic w_half;

    assign w_half = a ^ b;
    assign s      = w_half ^ cin;
    assign cout   = (a & b) | (cin & w_half);

endmodule : full_adder

`default_nettype wire

// File: rtl/four_bit_adder.sv
// ============================================================================
// Module      : four_bit_adder
// Description : WIDTH-bit ripple-carry adder with registered sum, carry, valid.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module four_bit_adder
    import four_bit_adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Y,
    output logic             C,
    output logic             out_valid
);

    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;

    logic [WIDTH-1:0] r_y;
    logic             r_c;
    logic             r_valid;

    assign w_carry[0] = Cin;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_cell
            full_adder u_fa (
                .a    (A[i]),
                .b    (B[i]),
                .cin  (w_carry[i]),
                .s    (w_sum[i]),
                .cout (w_carry[i+1])
            );
        end
    endgenerate

    // Sum/carry only load when qualified, so idle-cycle operand garbage never reaches the outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y     <= '0;
            r_c     <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_y <= w_sum;
                r_c <= w_carry[WIDTH];
            end
        end
    end

    assign Y         = r_y;
    assign C         = r_c;
    assign out_valid = r_valid;

endmodule : four_bit_adder

`default_nettype wire

// File: tb/tb_four_bit_adder.sv
// ============================================================================
// Module      : tb_four_bit_adder
// Description : Self-checking bench for four_bit_adder (WIDTH 4, 1 and 8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_four_bit_adder;

    logic clk;
    logic rst_n;

    logic [3:0] a4, b4, y4;
    logic       cin4, iv4, c4, ov4;

    logic [0:0] a1, b1, y1;
    logic       cin1, iv1, c1, ov1;

    logic [7:0] a8, b8, y8;
    logic       cin8, iv8, c8, ov8;

    int tests_run;
    int tests_failed;

    logic [4:0] exp_q[$];
    logic [1:0] q1[$];
    logic [8:0] q8[$];

    four_bit_adder #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .A(a4), .B(b4), .Cin(cin4),
        .in_valid(iv4), .Y(y4), .C(c4), .out_valid(ov4)
    );

    four_bit_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .A(a1), .B(b1), .Cin(cin1),
        .in_valid(iv1), .Y(y1), .C(c1), .out_valid(ov1)
    );

    four_bit_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .A(a8), .B(b8), .Cin(cin8),
        .in_valid(iv8), .Y(y8), .C(c8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; iv4 = 1'b1;
        repeat (4) begin
            @(negedge clk);
            tests_run++;
            if (y4 !== 4'h0 || c4 !== 1'b0 || ov4 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_hold: got Y=%h C=%b ov=%b, expected Y=0 C=0 ov=0", y4, c4, ov4);
            end
        end
        iv4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        a4 = 4'h5; b4 = 4'h3; cin4 = 1'b0; iv4 = 1'b1;
        @(posedge clk);
        #2;
        iv4 = 1'b0;
        tests_run++;
        if (y4 !== 4'h8 || c4 !== 1'b0 || ov4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_precapture: got Y=%h C=%b ov=%b, expected Y=8 C=0 ov=1", y4, c4, ov4);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (y4 !== 4'h0 || c4 !== 1'b0 || ov4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: got Y=%h C=%b ov=%b, expected Y=0 C=0 ov=0", y4, c4, ov4);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (y4 !== 4'h0 || c4 !== 1'b0 || ov4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_idle: got Y=%h C=%b ov=%b, expected Y=0 C=0 ov=0", y4, c4, ov4);
        end
    endtask

    // Directed vectors: {A, B, Cin, expected C, expected Y}
    task automatic test_directed();
        logic [13:0] vec[5];
        logic [4:0]  e;
        vec[0] = {4'h5, 4'h3, 1'b0, 1'b0, 4'h8};
        vec[1] = {4'hF, 4'h1, 1'b0, 1'b1, 4'h0};
        vec[2] = {4'hF, 4'hF, 1'b1, 1'b1, 4'hF};
        vec[3] = {4'h0, 4'h0, 1'b1, 1'b0, 4'h1};
        vec[4] = {4'h7, 4'h8, 1'b1, 1'b1, 4'h0};
        for (int i = 0; i <= 5; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if ({c4, y4} !== e || ov4 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL directed_%0d: got C=%b Y=%h ov=%b, expected C=%b Y=%h ov=1",
                             i - 1, c4, y4, ov4, e[4], e[3:0]);
                end
            end
            if (i < 5) begin
                {a4, b4, cin4} = vec[i][13:5];
                iv4 = 1'b1;
                exp_q.push_back(vec[i][4:0]);
            end else begin
                iv4 = 1'b0;
            end
        end
    endtask

    task automatic test_hold_valid();
        @(negedge clk);
        a4 = 4'h2; b4 = 4'h2; cin4 = 1'b0; iv4 = 1'b1;
        @(negedge clk);
        tests_run++;
        if (y4 !== 4'h4 || c4 !== 1'b0 || ov4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL hold_capture: got Y=%h C=%b ov=%b, expected Y=4 C=0 ov=1", y4, c4, ov4);
        end
        a4 = 4'h9; b4 = 4'h9; iv4 = 1'b0;
        @(negedge clk);
        tests_run++;
        if (y4 !== 4'h4 || c4 !== 1'b0 || ov4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_idle: got Y=%h C=%b ov=%b, expected Y=4 C=0 ov=0", y4, c4, ov4);
        end
        a4 = 4'hx; b4 = 4'hz; cin4 = 1'bx;
        repeat (2) @(negedge clk);
        tests_run++;
        if (y4 !== 4'h4 || c4 !== 1'b0 || ov4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL hold_xz: got Y=%h C=%b ov=%b, expected Y=4 C=0 ov=0", y4, c4, ov4);
        end
        cin4 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [4:0] e;
        int         errs;
        errs = 0;
        for (int i = 0; i <= 512; i++) begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests_run++;
                if ({c4, y4} !== e || ov4 !== 1'b1) begin
                    tests_failed++;
                    errs++;
                    if (errs <= 8)
                        $display("FAIL exhaustive_%0d: got C=%b Y=%h ov=%b, expected C=%b Y=%h ov=1",
                                 i - 1, c4, y4, ov4, e[4], e[3:0]);
                end
            end
            if (i < 512) begin
                a4   = i[8:5];
                b4   = i[4:1];
                cin4 = i[0];
                iv4  = 1'b1;
                exp_q.push_back({1'b0, a4} + {1'b0, b4} + {4'b0, cin4});
            end else begin
                iv4 = 1'b0;
            end
        end
    endtask

    task automatic test_widths();
        logic [1:0] e1;
        logic [8:0] e8;
        logic       last1, last8;
        last1 = 1'b0;
        last8 = 1'b0;
        for (int i = 0; i <= 200; i++) begin
            @(negedge clk);
            tests_run++;
            if (last1) begin
                e1 = q1.pop_front();
                if ({c1, y1} !== e1 || ov1 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL width1_%0d: got C=%b Y=%b ov=%b, expected C=%b Y=%b ov=1",
                             i, c1, y1, ov1, e1[1], e1[0]);
                end
            end else if (ov1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL width1_idle_%0d: got ov=%b, expected ov=0", i, ov1);
            end
            tests_run++;
            if (last8) begin
                e8 = q8.pop_front();
                if ({c8, y8} !== e8 || ov8 !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL width8_%0d: got C=%b Y=%h ov=%b, expected C=%b Y=%h ov=1",
                             i, c8, y8, ov8, e8[8], e8[7:0]);
                end
            end else if (ov8 !== 1'b0) begin
                tests_failed++;
                $display("FAIL width8_idle_%0d: got ov=%b, expected ov=0", i, ov8);
            end
            if (i < 200) begin
                a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
                iv1 = ($urandom_range(0, 3) != 0);
                a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
                iv8 = ($urandom_range(0, 3) != 0);
                if (i < 4) begin
                    a8 = 8'hFF; b8 = (i < 2) ? 8'hFF : 8'h00; cin8 = 1'b1; iv8 = 1'b1;
                end
            end else begin
                iv1 = 1'b0;
                iv8 = 1'b0;
            end
            if (iv1) q1.push_back({1'b0, a1} + {1'b0, b1} + {1'b0, cin1});
            if (iv8) q8.push_back({1'b0, a8} + {1'b0, b8} + {8'b0, cin8});
            last1 = iv1;
            last8 = iv8;
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        a1 = '0; b1 = '0; cin1 = 1'b0; iv1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0; iv8 = 1'b0;
        test_reset();
        test_directed();
        test_hold_valid();
        test_back_to_back();
        test_widths();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_four_bit_adder

`default_nettype wire

// File: doc/four_bit_adder.md
Name: four_bit_adder

Overview:
Registered ripple-carry adder: sums two WIDTH-bit operands plus a carry-in and produces a WIDTH-bit sum and a carry-out.
- Default WIDTH is 4.
- Used as the arithmetic core behind the board-level switch/LED adder top.
- Result, carry and an output-valid flag are registered, giving a one-cycle latency.

Parameters:
WIDTH, 4, operand and sum width in bits; legal range 1..32

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
Cin  input  1  carry-in, added at LSB weight
in_valid  input  1  qualifies A/B/Cin on the current cycle
Y  output  WIDTH  registered sum, (A+B+Cin) mod 2^WIDTH
C  output  1  registered carry-out, bit WIDTH of A+B+Cin
out_valid  output  1  high for one cycle when Y/C hold a newly captured result

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset:
  - rst_n low forces Y=0, C=0, out_valid=0 immediately, with no dependence on clk.
  - Reset asserted mid-operation discards any in-flight result.
  - After rst_n deasserts, the first capture happens on the next rising clk edge with in_valid=1.
- Combinational datapath: ripple-carry chain of WIDTH full-adder cells.
  - Cell i has inputs A[i], B[i] and carry c[i]; it outputs s[i] and c[i+1].
  - c[0]=Cin.
  - s = a XOR b XOR cin.
  - cout = (a AND b) OR (cin AND (a XOR b)).
- Sum is the concatenation {c[WIDTH], s[WIDTH-1:0]}, which equals A+B+Cin exactly.
  - Maximum value is 2^(WIDTH+1)-1.
  - No saturation. Overflow wraps Y, and C reports the carry.
- Capture:
  - On a rising clk with in_valid=1: Y<=s, C<=c[WIDTH], out_valid<=1.
  - On a rising clk with in_valid=0: Y and C hold their previous values, out_valid<=0.
- Latency: exactly 1 cycle from the in_valid sample to out_valid/Y/C. Throughput is one result per cycle; back-to-back in_valid is allowed.
- No back-pressure: the consumer must accept a result in the cycle out_valid is high.
- Operands are unsigned. No signed-overflow flag is produced.
- X or Z on A/B/Cin while in_valid=0 must not disturb Y/C.

Decomposition:
- Shared package: default WIDTH constant ADDER_WIDTH=4 only. No typedefs are needed.
- One sub-module, full_adder (ports a, b, cin, s, cout), purely combinational.
  - Instantiate it WIDTH times with a generate loop, chained LSB to MSB.
- The top holds only the chain, the output registers and the valid flop.

Test Plan:
1. Reset: hold rst_n=0 with clk running and in_valid=1, A=4'hF, B=4'hF -> Y=0, C=0, out_valid=0 throughout. Assert rst_n asynchronously between edges -> outputs clear without waiting for an edge.
2. Basic add: A=5, B=3, Cin=0, in_valid=1 -> next cycle Y=8, C=0, out_valid=1.
3. Carry/wrap: A=4'hF, B=1, Cin=0 -> Y=0, C=1. Then A=4'hF, B=4'hF, Cin=1 -> Y=4'hF, C=1.
4. Carry-in only: A=0, B=0, Cin=1 -> Y=1, C=0. Then A=4'h7, B=4'h8, Cin=1 -> Y=0, C=1 (full carry propagation through all cells).
5. Hold/valid: apply A=2, B=2 with in_valid=1, then in_valid=0 with A=9, B=9 -> Y stays 4, C=0, out_valid pulses for exactly one cycle.
6. Exhaustive: all 512 combinations of A, B, Cin, issued back-to-back -> each {C,Y} equals A+B+Cin one cycle later. Also run WIDTH=1 and WIDTH=8 builds through random checks against a reference sum.
